// File: rtl/desplazamiento_pkg.sv
// Shared helpers for the f[k] sample delay line.
// Fill width, depth limit and flattened-bus slicing.
package desplazamiento_pkg;

  localparam int MAX_DEPTH = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r++;
    end
    return r;
  endfunction

  function automatic int tap_lsb(input int i, input int n);
    return i * n;
  endfunction

endpackage

// File: rtl/desplazamiento_fk_taps_detector_flanco.sv
// Rising-edge detector for a slow shift strobe.
// Only built when SHIFT_EDGE_EN is defined.
`ifdef SHIFT_EDGE_EN
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_rise
);

  logic r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d <= 1'b0;
    end else begin
      r_d <= i_lvl;
    end
  end

  assign o_rise = i_lvl & ~r_d;

endmodule
`endif

// File: rtl/desplazamiento_fk_taps.sv
// Sample delay line f[k]..f[k-DEPTH+1] with fill tracking and shift ack.
// Define SHIFT_EDGE_EN to treat shift as a level strobe (one event per rise).
module desplazamiento_fk_taps
  import desplazamiento_pkg::*;
#(
  parameter  int N     = 25,
  parameter  int DEPTH = 3,
  localparam int FW    = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     In,
  input  logic             shift,
  input  logic             clear,
  output logic [N*DEPTH-1:0] taps,
  output logic [FW-1:0]    fill,
  output logic             full,
  output logic             shift_ack
);

  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("desplazamiento_fk_taps: DEPTH out of range");
  end

  logic [N-1:0]  r_tap [DEPTH];
  logic [FW-1:0] r_fill;
  logic          r_ack;
  logic          w_evt;

`ifdef SHIFT_EDGE_EN
  detector_flanco u_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_lvl  (shift),
    .o_rise (w_evt)
  );
`else
  assign w_evt = shift;
`endif

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tap[gi] <= '0;
        end else if (clear) begin
          r_tap[gi] <= '0;
        end else if (w_evt) begin
          r_tap[gi] <= In;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tap[gi] <= '0;
        end else if (clear) begin
          r_tap[gi] <= '0;
        end else if (w_evt) begin
          r_tap[gi] <= r_tap[gi-1];
        end
      end
    end
    assign taps[tap_lsb(gi, N) +: N] = r_tap[gi];
  end

  // clear wins over a coincident event; that event is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
      r_ack  <= 1'b0;
    end else if (clear) begin
      r_fill <= '0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= w_evt;
      if (w_evt && r_fill != FILL_MAX) begin
        r_fill <= r_fill + FW'(1);
      end
    end
  end

  assign fill      = r_fill;
  assign full      = (r_fill == FILL_MAX);
  assign shift_ack = r_ack;

endmodule

// File: tb/tb_desplazamiento_fk_taps.sv
// Bench for desplazamiento_fk_taps: queue model plus directed vectors.
// Covers N=25/DEPTH=3 and N=8/DEPTH=16 instances, either shift mode.
module tb_desplazamiento_fk_taps;

  logic         clk;
  logic         rst_n;
  logic         shift;
  logic         clear;
  logic [24:0]  in_a;
  logic [7:0]   in_b;
  logic [74:0]  taps_a;
  logic [1:0]   fill_a;
  logic         full_a;
  logic         ack_a;
  logic [127:0] taps_b;
  logic [4:0]   fill_b;
  logic         full_b;
  logic         ack_b;

  desplazamiento_fk_taps #(.N(25), .DEPTH(3)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (in_a),
    .shift     (shift),
    .clear     (clear),
    .taps      (taps_a),
    .fill      (fill_a),
    .full      (full_a),
    .shift_ack (ack_a)
  );

  desplazamiento_fk_taps #(.N(8), .DEPTH(16)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (in_b),
    .shift     (shift),
    .clear     (clear),
    .taps      (taps_b),
    .fill      (fill_b),
    .full      (full_b),
    .shift_ack (ack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: newest sample at the queue front, size is the fill count
  logic [24:0] qa[$];
  logic [7:0]  qb[$];
  bit m_ack;
  bit m_prev;
  bit m_ev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      m_ack  = 1'b0;
      m_prev = 1'b0;
    end else begin
`ifdef SHIFT_EDGE_EN
      m_ev = shift && !m_prev;
`else
      m_ev = shift;
`endif
      m_prev = shift;
      if (clear) begin
        qa.delete();
        qb.delete();
        m_ack = 1'b0;
      end else begin
        m_ack = m_ev;
        if (m_ev) begin
          qa.push_front(in_a);
          qb.push_front(in_b);
          if (qa.size() > 3) void'(qa.pop_back());
          if (qb.size() > 16) void'(qb.pop_back());
        end
      end
    end
  end

  function automatic logic [74:0] exp_a();
    logic [74:0] r;
    r = '0;
    for (int i = 0; i < qa.size(); i++) r[i*25 +: 25] = qa[i];
    return r;
  endfunction

  function automatic logic [127:0] exp_b();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < qb.size(); i++) r[i*8 +: 8] = qb[i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("m_taps_a", taps_a, exp_a());
      chk("m_fill_a", fill_a, qa.size());
      chk("m_full_a", full_a, qa.size() == 3);
      chk("m_ack_a", ack_a, m_ack);
      chk("m_taps_b", taps_b, exp_b());
      chk("m_fill_b", fill_b, qb.size());
      chk("m_full_b", full_b, qb.size() == 16);
      chk("m_ack_b", ack_b, m_ack);
    end
  end

  // Apply inputs, then land 1 time unit after the accepting edge
  task automatic cyc(input bit s, input bit c,
                     input logic [24:0] da, input logic [7:0] db);
    shift = s;
    clear = c;
    in_a  = da;
    in_b  = db;
    @(posedge clk);
    #1;
  endtask

  int acks;

  initial begin
    rst_n = 1'b0;
    shift = 1'b0;
    clear = 1'b0;
    in_a  = '0;
    in_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_taps", taps_a, 75'd0);
    chk("rst_fill", fill_a, 2'd0);
    chk("rst_full", full_a, 1'b0);
    chk("rst_ack", ack_a, 1'b0);
    rst_n   = 1'b1;
    run_cmp = 1'b1;

    cyc(1, 0, 25'd5, 8'd0);
    chk("fill_1", fill_a, 2'd1);
    chk("ack_1", ack_a, 1'b1);
    cyc(0, 0, 25'd99, 8'd0);
    chk("ack_idle", ack_a, 1'b0);
    cyc(1, 0, 25'd7, 8'd0);
    chk("fill_2", fill_a, 2'd2);
    chk("full_2", full_a, 1'b0);
    cyc(0, 0, 25'd0, 8'd0);
    cyc(1, 0, 25'd9, 8'd0);
    chk("order", taps_a, {25'd5, 25'd7, 25'd9});
    chk("fill_3", fill_a, 2'd3);
    chk("full_3", full_a, 1'b1);

    cyc(0, 0, 25'd0, 8'd0);
    cyc(1, 0, 25'd11, 8'd0);
    chk("sat_taps", taps_a, {25'd7, 25'd9, 25'd11});
    chk("sat_fill", fill_a, 2'd3);
    chk("sat_full", full_a, 1'b1);

    cyc(0, 0, 25'd0, 8'd0);
    cyc(1, 1, 25'd13, 8'd13);
    chk("clr_taps", taps_a, 75'd0);
    chk("clr_fill", fill_a, 2'd0);
    chk("clr_ack", ack_a, 1'b0);
    cyc(0, 0, 25'd0, 8'd0);
    chk("clr_after", taps_a, 75'd0);

    acks = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 25'd3, 8'd3);
      if (ack_a) acks++;
    end
    cyc(0, 0, 25'd0, 8'd0);
    if (ack_a) acks++;
`ifdef SHIFT_EDGE_EN
    chk("hold_acks", acks, 1);
    chk("hold_fill", fill_a, 2'd1);
    chk("hold_taps", taps_a, {25'd0, 25'd0, 25'd3});
`else
    chk("hold_acks", acks, 10);
    chk("hold_fill", fill_a, 2'd3);
    chk("hold_taps", taps_a, {25'd3, 25'd3, 25'd3});
`endif

    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_taps", taps_a, 75'd0);
    chk("arst_fill", fill_a, 2'd0);
    chk("arst_full", full_a, 1'b0);
    chk("arst_ack", ack_a, 1'b0);
    chk("arst_taps_b", taps_b, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cyc(1, 0, 25'd1, 8'h80);
    cyc(0, 0, 25'd0, 8'h00);
    cyc(1, 0, 25'd2, 8'hFF);
    chk("b_slices", taps_b, {112'd0, 8'h80, 8'hFF});
    chk("b_fill", fill_b, 5'd2);
    chk("b_full", full_b, 1'b0);
    cyc(0, 0, 25'd0, 8'h00);

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/desplazamiento_fk_taps.md
Name: desplazamiento_fk_taps

Overview:
- Parametrised sample delay line for the fixed-point filter/controller datapath. Holds the current sample f[k] and DEPTH-1 previous samples f[k-1]..f[k-DEPTH+1].
- Fully synchronous to clk. The shift request is an enable or edge event, not a clock.
- Adds fill tracking, synchronous clear and a shift acknowledge, so the downstream difference-equation stage knows when all taps hold real data.

Parameters:
- N, 25, sample width in bits (signed fixed-point; the block treats it as opaque bits).
- DEPTH, 3, number of taps including the current sample; legal range 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- In  in  N  new sample f[k].
- shift  in  1  shift request. Its meaning depends on SHIFT_EDGE_EN.
- clear  in  1  synchronous clear of all taps and the fill count.
- taps  out  N*DEPTH  flattened taps. Bits [N-1:0] = f[k]; slice i = f[k-i].
- fill  out  $clog2(DEPTH+1)  number of valid taps, 0..DEPTH.
- full  out  1  high when fill == DEPTH.
- shift_ack  out  1  one-cycle pulse after each accepted shift.

Behaviour:
- Reset (rst_n low, asynchronous): all taps = 0, fill = 0, full = 0, shift_ack = 0, edge-detect history = 0. Reset is released synchronously by the next clk edge.
- Shift event: decided per clk edge (see Optional Feature). On an event:
  - tap[0] <= In.
  - tap[i] <= tap[i-1] for i = 1..DEPTH-1.
  - The old tap[DEPTH-1] is discarded.
- Latency: taps update at the same clk edge that accepts the event and are visible the following cycle. shift_ack is registered and is high during the cycle after the accepting edge.
- fill:
  - Increments by 1 per event and saturates at DEPTH; it never wraps.
  - full is combinational from the fill register (fill == DEPTH).
  - Further shifts while full still shift the data; fill stays at DEPTH.
- clear (synchronous, priority over shift):
  - Taps = 0 and fill = 0 at that edge.
  - shift_ack = 0 in the next cycle, even if a shift event coincided.
  - A coincident shift event is dropped, not deferred.
- No event and no clear: all state holds.
- In is sampled only at the accepting edge. It may change freely at other times.
- Asserting rst_n low mid-operation aborts immediately. A pending shift is lost, and the state equals the reset values.
- All outputs are registered except full.

Optional Feature:
- Macro: SHIFT_EDGE_EN.
- Defined:
  - shift is a level from a slow strobe, so it may stay high for many cycles.
  - The block registers shift_d and accepts an event only when shift && !shift_d, i.e. one event per rising edge regardless of high time.
  - shift_d resets to 0, so shift already high on the first cycle after reset counts as an edge.
  - clear does not touch shift_d.
- Undefined:
  - shift is a synchronous enable; every cycle with shift = 1 is an event.
  - No history register exists.

Decomposition:
- Package desplazamiento_pkg:
  - function clog2 for the fill width.
  - localparam MAX_DEPTH = 16.
  - function tap_lsb(i) = i*N for slicing the flattened bus.
- Sub-module detector_flanco (rising-edge detector, clk/rst_n), instantiated only under SHIFT_EDGE_EN. Otherwise the block is a single module with a generate loop over taps.

Test Plan:
- Reset: N=25, DEPTH=3. Drive rst_n = 0 mid-stream with taps non-zero → taps = 0, fill = 0, full = 0, shift_ack = 0 immediately, without waiting for a clk edge.
- Fill and order: shift In = 5, then 7, then 9 →
  - taps = {9,7,5}, i.e. f[k]=9, f[k-1]=7, f[k-2]=5.
  - fill runs 1, 2, 3; full rises after the third.
  - shift_ack pulses once per shift.
- Saturation: with the line full, shift In = 11 → taps = {11,9,7}, fill stays 3, full stays 1.
- Clear collision: assert clear and shift on the same edge with In = 13 → taps = 0, fill = 0, no shift_ack, and 13 appears in no tap.
- Edge mode (SHIFT_EDGE_EN defined): hold shift high 10 cycles with In = 3 → exactly one event, fill = 1, one shift_ack. Without the macro, the same stimulus gives 10 events, fill = 3, and 10 consecutive shift_ack cycles.
- Width corners: N=8, DEPTH=16, shift In = 8'h80 then 8'hFF →
  - slice 0 = 8'hFF, slice 1 = 8'h80; the rest stay 0.
  - fill = 2, and fill width = 5 bits.
